// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and decode.
// Optional same-cycle bypass on an empty queue: INST_FIFO_BYPASS_EN.
module inst_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid_1,
  input  logic        in_valid_2,
  input  logic [31:0] in_inst_1,
  input  logic [31:0] in_inst_2,
  input  logic [31:0] in_pc_1,
  input  logic [31:0] in_pc_2,
  output logic        full,
  output logic        empty,
  output logic        out_valid_1,
  output logic        out_valid_2,
  output logic [31:0] out_inst_1,
  output logic [31:0] out_inst_2,
  output logic [31:0] out_pc_1,
  output logic [31:0] out_pc_2,
  input  logic        read_en_1,
  input  logic        read_en_2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  logic          w_byp;
  logic          w_sv1;
  logic          w_sv2;
  entry_t        w_head;
  entry_t        w_next;
  entry_t        w_slot1;
  entry_t        w_slot2;
  entry_t        w_d0;
  logic          w_r1;
  logic          w_r2;
  logic [1:0]    w_nr;
  logic [1:0]    w_nrp;
  logic [1:0]    w_nw;
  logic [CW:0]   w_free;
  logic          w_acc1;
  logic          w_acc2;

`ifdef INST_FIFO_BYPASS_EN
  assign w_byp = (r_count == '0) && !flush && !rst;
`else
  assign w_byp = 1'b0;
`endif

  assign w_sv1   = r_count >= CW'(1);
  assign w_sv2   = r_count >= CW'(2);
  assign w_head  = r_mem[r_rptr];
  assign w_next  = r_mem[r_rptr + AW'(1)];
  assign w_slot1 = '{inst: in_inst_1, pc: in_pc_1};
  assign w_slot2 = '{inst: in_inst_2, pc: in_pc_2};

  always_comb begin
    out_valid_1 = w_sv1;
    out_valid_2 = w_sv2;
    out_inst_1  = w_sv1 ? w_head.inst : '0;
    out_pc_1    = w_sv1 ? w_head.pc   : '0;
    out_inst_2  = w_sv2 ? w_next.inst : '0;
    out_pc_2    = w_sv2 ? w_next.pc   : '0;
    if (w_byp) begin
      out_valid_1 = in_valid_1;
      out_valid_2 = in_valid_1 && in_valid_2;
      out_inst_1  = in_valid_1 ? in_inst_1 : '0;
      out_pc_1    = in_valid_1 ? in_pc_1   : '0;
      out_inst_2  = out_valid_2 ? in_inst_2 : '0;
      out_pc_2    = out_valid_2 ? in_pc_2   : '0;
    end
  end

  assign w_r1 = read_en_1 && out_valid_1;
  assign w_r2 = w_r1 && read_en_2 && out_valid_2;
  assign w_nr = {1'b0, w_r1} + {1'b0, w_r2};

  // Space freed by this cycle's reads is usable by this cycle's writes
  assign w_free = (CW+1)'(DEPTH) - {1'b0, r_count} + (CW+1)'(w_nr);
  assign w_acc1 = in_valid_1 && (w_free >= (CW+1)'(1));
  assign w_acc2 = in_valid_1 && in_valid_2 && (w_free >= (CW+1)'(2));

  always_comb begin
    w_nw  = {1'b0, w_acc1} + {1'b0, w_acc2};
    w_nrp = w_nr;
    w_d0  = w_slot1;
    if (w_byp) begin
      w_nrp = 2'd0;
      w_nw  = {1'b0, w_acc1} + {1'b0, w_acc2} - w_nr;
      if (w_r1) w_d0 = w_slot2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_nw);
      r_rptr  <= r_rptr + AW'(w_nrp);
      r_count <= r_count + CW'(w_nw) - CW'(w_nrp);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (w_nw != 2'd0) r_mem[r_wptr] <= w_d0;
      if (w_nw == 2'd2) r_mem[r_wptr + AW'(1)] <= w_slot2;
    end
  end

  assign full  = r_count > CW'(DEPTH - 2);
  assign empty = r_count == '0;

endmodule

// File: tb/tb_inst_fifo.sv
// Randomized self-checking bench for inst_fifo against a queue model.
// Build with +define+INST_FIFO_BYPASS_EN to cover the bypass path.
module tb_inst_fifo;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid_1, in_valid_2;
  logic [31:0] in_inst_1, in_inst_2, in_pc_1, in_pc_2;
  logic        full, empty;
  logic        out_valid_1, out_valid_2;
  logic [31:0] out_inst_1, out_inst_2, out_pc_1, out_pc_2;
  logic        read_en_1, read_en_2;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .in_inst_1(in_inst_1), .in_inst_2(in_inst_2),
    .in_pc_1(in_pc_1), .in_pc_2(in_pc_2),
    .full(full), .empty(empty),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_inst_1(out_inst_1), .out_inst_2(out_inst_2),
    .out_pc_1(out_pc_1), .out_pc_2(out_pc_2),
    .read_en_1(read_en_1), .read_en_2(read_en_2)
  );

  always #5 clk = ~clk;

  ent_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] g_pc = 32'h0000_1000;

  function automatic bit bypass_now();
    bit b = 1'b0;
`ifdef INST_FIFO_BYPASS_EN
    b = (q.size() == 0) && !flush && !rst;
`endif
    return b;
  endfunction

  function automatic logic [131:0] expv();
    logic v1, v2;
    ent_t e1, e2;
    if (rst) return {130'b0, 1'b0, 1'b1};
    if (bypass_now()) begin
      v1 = in_valid_1;
      v2 = in_valid_1 && in_valid_2;
      e1 = v1 ? {in_inst_1, in_pc_1} : '0;
      e2 = v2 ? {in_inst_2, in_pc_2} : '0;
    end else begin
      v1 = q.size() >= 1;
      v2 = q.size() >= 2;
      e1 = v1 ? q[0] : '0;
      e2 = v2 ? q[1] : '0;
    end
    return {v1, v2, e1, e2, q.size() > DEPTH - 2, q.size() == 0};
  endfunction

  function automatic logic [131:0] obs();
    return {out_valid_1, out_valid_2, out_inst_1, out_pc_1,
            out_inst_2, out_pc_2, full, empty};
  endfunction

  task automatic set_in(bit v1, bit v2, bit re1, bit re2, bit fl);
    in_valid_1 = v1;
    in_valid_2 = v2;
    in_inst_1  = $urandom;
    in_inst_2  = $urandom;
    in_pc_1    = g_pc;
    in_pc_2    = g_pc + 32'd4;
    read_en_1  = re1;
    read_en_2  = re2;
    flush      = fl;
    if (v1) g_pc = g_pc + (v2 ? 32'd8 : 32'd4);
  endtask

  task automatic tick();
    logic [131:0] e;
    bit   byp, r1, r2;
    int   nr;
    ent_t s[$];
    e   = expv();
    byp = bypass_now();
    r1  = read_en_1 && e[131];
    r2  = r1 && read_en_2 && e[130];
    nr  = int'(r1) + int'(r2);
    if (in_valid_1) s.push_back({in_inst_1, in_pc_1});
    if (in_valid_1 && in_valid_2) s.push_back({in_inst_2, in_pc_2});
    @(posedge clk);
    if (rst || flush) q.delete();
    else if (byp) begin
      for (int k = nr; k < s.size(); k++) q.push_back(s[k]);
    end else begin
      for (int k = 0; k < nr; k++) void'(q.pop_front());
      foreach (s[k]) if (q.size() < DEPTH) q.push_back(s[k]);
    end
    #1;
  endtask

  task automatic clear();
    set_in(0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 1, 1, 1, 0);
    #1;
    n_chk++;
    if (obs() !== {130'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset obs=%h exp=zero,empty", obs());
    end
    tick();
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL reset_hold obs=%h exp=%h", obs(), expv());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear();
    set_in(0, 0, 0, 0, 0);
    in_valid_1 = 1; in_inst_1 = 32'h24010001; in_pc_1 = 32'hBFC00000;
    in_valid_2 = 1; in_inst_2 = 32'h24020002; in_pc_2 = 32'hBFC00004;
    #1;
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL basic_wr obs=%h exp=%h", obs(), expv());
    end
`ifndef INST_FIFO_BYPASS_EN
    n_chk++;
    if ({out_valid_1, out_valid_2, out_pc_1} !== 34'b0) begin
      n_fail++;
      $display("FAIL basic_wr_zero got v=%b%b pc=%h want 0", out_valid_1, out_valid_2, out_pc_1);
    end
`endif
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if ({out_valid_1, out_valid_2, empty, out_inst_1, out_pc_1, out_inst_2, out_pc_2}
        !== {3'b110, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004}) begin
      n_fail++;
      $display("FAIL basic_rd got pc1=%h pc2=%h empty=%b want BFC00000 BFC00004 0",
               out_pc_1, out_pc_2, empty);
    end
    tick();
  endtask

  task automatic test_fill();
    logic [31:0] base;
    clear();
    base = g_pc;
    for (int i = 0; i <= DEPTH / 2; i++) begin
      set_in(1, 1, 0, 0, 0);
      #1;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL fill[%0d] obs=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
    n_chk++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full got %b want 1", full);
    end
    for (int i = 0; i <= DEPTH / 2; i++) begin
      set_in(0, 0, 1, 1, 0);
      #1;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL drain[%0d] obs=%h exp=%h", i, obs(), expv());
      end
      if (i < DEPTH / 2) begin
        n_chk++;
        if (out_pc_1 !== base + 32'(8 * i)) begin
          n_fail++;
          $display("FAIL drain_pc[%0d] got %h want %h", i, out_pc_1, base + 32'(8 * i));
        end
      end
      tick();
    end
    n_chk++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty got %b want 1", empty);
    end
  endtask

  task automatic test_steady();
    logic [31:0] base;
    clear();
    base = g_pc;
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_in(1, 1, 1, 1, 0);
      #1;
      n_chk++;
      if (obs() !== expv() || out_pc_1 !== base + 32'(8 * i)
          || out_pc_2 !== out_pc_1 + 32'd4 || q.size() != 4) begin
        n_fail++;
        $display("FAIL steady[%0d] pc1=%h pc2=%h want %h obs=%h exp=%h",
                 i, out_pc_1, out_pc_2, base + 32'(8 * i), obs(), expv());
      end
      tick();
    end
  endtask

  task automatic test_partial_reads();
    clear();
    set_in(1, 0, 0, 0, 0);
    tick();
    set_in(0, 1, 0, 1, 0);
    #1;
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL rd2_only obs=%h exp=%h", obs(), expv());
    end
    tick();
    set_in(0, 0, 1, 1, 0);
    #1;
    n_chk++;
    if (empty !== 1'b0 || out_valid_1 !== 1'b1 || out_valid_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL rd2_kept empty=%b v1=%b v2=%b want 0 1 0", empty, out_valid_1, out_valid_2);
    end
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (empty !== 1'b1 || out_valid_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_one empty=%b v1=%b want 1 0", empty, out_valid_1);
    end
  endtask

  task automatic test_flush();
    clear();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 0, 0, 0);
      tick();
    end
    set_in(1, 1, 1, 1, 1);
    #1;
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL flush_cyc obs=%h exp=%h", obs(), expv());
    end
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (obs() !== {130'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_after obs=%h exp=zero,empty", obs());
    end
  endtask

`ifdef INST_FIFO_BYPASS_EN
  task automatic test_bypass();
    logic [31:0] pc1, pc2;
    clear();
    pc1 = g_pc;
    pc2 = g_pc + 32'd4;
    set_in(1, 1, 1, 0, 0);
    #1;
    n_chk++;
    if (out_valid_1 !== 1'b1 || out_pc_1 !== pc1 || out_pc_2 !== pc2) begin
      n_fail++;
      $display("FAIL byp_same v1=%b pc1=%h pc2=%h want 1 %h %h", out_valid_1, out_pc_1, out_pc_2, pc1, pc2);
    end
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (out_valid_1 !== 1'b1 || out_valid_2 !== 1'b0 || out_pc_1 !== pc2) begin
      n_fail++;
      $display("FAIL byp_rest v1=%b v2=%b pc1=%h want 1 0 %h", out_valid_1, out_valid_2, out_pc_1, pc2);
    end
    tick();
  endtask
`endif

  task automatic test_midreset();
    clear();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 0, 0);
      tick();
    end
    set_in(1, 1, 0, 0, 0);
    rst = 1'b1;
    q.delete();
    #1;
    n_chk++;
    if (obs() !== {130'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset obs=%h exp=zero,empty", obs());
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
             $urandom_range(2, 0) != 0, $urandom_range(1, 0) == 1,
             $urandom_range(39, 0) == 0);
      #1;
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random[%0d] obs=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_steady();
    test_partial_reads();
    test_flush();
`ifdef INST_FIFO_BYPASS_EN
    test_bypass();
`endif
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
